// File: rtl/controlador_ram.sv
// Burst controller for a synchronous single-port RAM: turns one request into N
// consecutive address beats (write or read) and returns read data in address order.
module controlador_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_dir,
  input  logic [7:0] req_len,
  input  logic [7:0] req_dato,
  output logic [7:0] direccion,
  output logic [7:0] dato_e,
  output logic       EN,
  input  logic [7:0] dato_s,
  output logic       resp_valid,
  output logic [7:0] resp_dato,
  output logic       fin
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high exactly while the FSM is IDLE. resp_valid has no ready and
  // is consumed in the cycle it is shown.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAFAGA  = 2'd1,
    DRENAJE = 2'd2
  } estado_t;

  estado_t    estado_q;
  estado_t    estado_d;
  logic [7:0] restantes_q;
  logic [7:0] restantes_d;
  logic       we_q;
  logic       we_d;
  logic       rd_pend_q;
  logic       rd_pend_d;
  logic [7:0] direccion_d;
  logic [7:0] dato_e_d;
  logic       en_d;
  logic       fin_d;
  logic       resp_valid_d;
  logic [7:0] resp_dato_d;

  assign req_ready = (estado_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      IDLE:    if (req_valid) estado_d = RAFAGA;
      RAFAGA:  if (restantes_q == 8'd0) estado_d = we_q ? IDLE : DRENAJE;
      DRENAJE: if (!rd_pend_q) estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Next values of the registered RAM and response outputs.
  always_comb begin
    direccion_d  = direccion;
    dato_e_d     = dato_e;
    en_d         = 1'b0;
    restantes_d  = restantes_q;
    we_d         = we_q;
    fin_d        = 1'b0;
    rd_pend_d    = (estado_q == RAFAGA) && !we_q;
    resp_valid_d = rd_pend_q;
    resp_dato_d  = rd_pend_q ? dato_s : resp_dato;
    unique case (estado_q)
      IDLE: begin
        if (req_valid) begin
          direccion_d = req_dir;
          en_d        = req_we;
          we_d        = req_we;
          restantes_d = req_len;
          if (req_we) dato_e_d = req_dato;
        end
      end
      RAFAGA: begin
        if (restantes_q != 8'd0) begin
          direccion_d = direccion + 8'd1;
          restantes_d = restantes_q - 8'd1;
          if (we_q) begin
            dato_e_d = dato_e + 8'd1;
            en_d     = 1'b1;
          end
        end else begin
          fin_d = we_q;
        end
      end
      // The last read beat is still one RAM cycle plus one register away.
      DRENAJE: fin_d = !rd_pend_q;
      default: fin_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      direccion   <= 8'd0;
      dato_e      <= 8'd0;
      EN          <= 1'b0;
      restantes_q <= 8'd0;
      we_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_dato   <= 8'd0;
      fin         <= 1'b0;
    end else begin
      direccion   <= direccion_d;
      dato_e      <= dato_e_d;
      EN          <= en_d;
      restantes_q <= restantes_d;
      we_q        <= we_d;
      rd_pend_q   <= rd_pend_d;
      resp_valid  <= resp_valid_d;
      resp_dato   <= resp_dato_d;
      fin         <= fin_d;
    end
  end

endmodule

// File: doc/controlador_ram.md
CONTROLADOR_RAM -- requirements
Module: controlador_ram

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high; sampled on rising edge of clk.
REQ-003 req_valid  input  1  burst request present.
REQ-004 req_ready  output  1  controller can accept a request; high only in state IDLE.
REQ-005 req_we  input  1  1 = write burst, 0 = read burst.
REQ-006 req_dir  input  8  burst base address.
REQ-007 req_len  input  8  beats minus one; burst length N = req_len+1, range 1..256.
REQ-008 req_dato  input  8  write seed; beat k writes (req_dato + k) mod 256.
REQ-009 direccion  output  8  RAM address, registered.
REQ-010 dato_e  output  8  RAM write data, registered.
REQ-011 EN  output  1  RAM write enable, registered; 1 only during write beats.
REQ-012 dato_s  input  8  RAM read data; valid the cycle after the RAM samples direccion.
REQ-013 resp_valid  output  1  read beat valid, registered; no backpressure.
REQ-014 resp_dato  output  8  read beat data, registered.
REQ-015 fin  output  1  one-cycle pulse marking burst completion.

Function
REQ-016 The FSM SHALL have states IDLE, RAFAGA and DRENAJE.
REQ-017 A request SHALL be accepted on edge E0 when req_valid=1 and state=IDLE; base address, N, we and seed are latched at E0.
REQ-018 Beat k (k=0..N-1) SHALL be presented on direccion/dato_e/EN in cycle E0+1+k.
REQ-019 Beat k SHALL use address (req_dir + k) mod 256, wrapping 255 -> 0.
REQ-020 Write beats SHALL drive EN=1 and dato_e=(req_dato+k) mod 256; read beats SHALL drive EN=0.
REQ-021 After the last write beat the FSM SHALL return to IDLE; fin=1 in cycle E0+N+1.
REQ-022 After the last read address the FSM SHALL enter DRENAJE until all read data is returned.
REQ-023 Read beat k SHALL appear as resp_valid=1, resp_dato=RAM[(req_dir+k) mod 256] in cycle E0+k+3, in address order.
REQ-024 For reads, fin=1 SHALL occur in cycle E0+N+3, the cycle after the last resp_valid; the FSM is then in IDLE.
REQ-025 resp_valid SHALL be 0 whenever no read beat is returning; resp_valid SHALL never be 1 during write bursts.
REQ-026 In IDLE, EN SHALL be 0 and direccion and dato_e SHALL hold their last values.
REQ-027 req_ready SHALL be 1 in the fin cycle, so a back-to-back request can be accepted on that cycle's edge.
REQ-028 req_valid outside IDLE SHALL be ignored, with no effect on the active burst.
REQ-029 req_len=255 SHALL produce exactly 256 beats covering every address once.
REQ-030 req_len=0 SHALL produce exactly one beat.

Reset
REQ-031 With rst=1 at an edge, the block SHALL enter IDLE with direccion=0, dato_e=0, EN=0, resp_valid=0, resp_dato=0, fin=0, req_ready=1 in the next cycle.
REQ-032 Reset mid-burst SHALL abort the burst: EN=0 from the next cycle, in-flight read data discarded, no resp_valid, no fin.
REQ-033 rst SHALL take priority over a simultaneous req_valid.

Verification
REQ-034 Write req_dir=0, req_len=1, req_dato=64 -> EN=1 at addresses 0 and 1 with dato_e 64 and 65 in cycles E0+1 and E0+2; fin in cycle E0+3.
REQ-035 Read req_dir=0, req_len=1 after REQ-034 -> resp_dato 64 in cycle E0+3 and 65 in cycle E0+4; fin in cycle E0+5.
REQ-036 Write req_dir=254, req_len=3, req_dato=10 -> addresses 254, 255, 0, 1 with data 10..13; read-back returns 10, 11, 12, 13.
REQ-037 Read req_len=255 -> exactly 256 resp_valid pulses, then one fin; req_ready=0 throughout the burst.
REQ-038 Assert rst in cycle E0+2 of a 4-beat read -> no resp_valid or fin afterwards; req_ready=1 in the cycle after the reset edge.
REQ-039 Hold req_valid=1 continuously -> bursts chain with acceptance on each fin cycle; req_valid during a burst has no effect.
